// File: rtl/beacon_pkg.sv
// Shared beacon types and defaults, used by the period detector and by the divider's users.
package beacon_pkg;

    typedef enum logic {IDLE, MEASURE} bpd_state_t;

    localparam int unsigned BEACON_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/beacon_period_detect_if.sv
// Strobe, observation, expectation and measurement signals of one beacon period detector.
interface beacon_period_detect_if
    import beacon_pkg::*;
#(
    parameter int unsigned WIDTH = BEACON_WIDTH_DEFAULT
);
    logic             en;
    logic             sig_in;
    logic [WIDTH-1:0] N_expect;
    logic [WIDTH-1:0] tol;
    logic [WIDTH-1:0] n_meas;
    logic             meas_valid;
    logic             locked;

    modport master (
        output en, sig_in, N_expect, tol,
        input  n_meas, meas_valid, locked
    );

    modport slave (
        input  en, sig_in, N_expect, tol,
        output n_meas, meas_valid, locked
    );
endinterface

// File: rtl/beacon_sync_edge.sv
// Input sampling and rising-edge strobe for the period detector.
// BEACON_SYNC_EN inserts a 2-flop synchroniser clocked every clk, ahead of the en-qualified edge detect.
module beacon_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sig_in,
    output logic s,
    output logic rise
);
    logic prev;

`ifdef BEACON_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], sig_in};
    end

    assign s = sync_q[1];
`else
    assign s = sig_in;
`endif

    // prev only advances on strobe samples, so edges are seen in the en time base
    always_ff @(posedge clk) begin
        if (rst)     prev <= 1'b0;
        else if (en) prev <= s;
    end

    assign rise = en & s & ~prev;
endmodule

// File: rtl/beacon_period_detect.sv
// Beacon period detector: measures rising-edge spacing of sig_in in en samples and locks after
// LOCK_CNT consecutive in-tolerance periods. Define BEACON_SYNC_EN to synchronise sig_in.
module beacon_period_detect
    import beacon_pkg::*;
#(
    parameter int unsigned WIDTH    = BEACON_WIDTH_DEFAULT,
    parameter int unsigned LOCK_CNT = 4
) (
    input logic                   clk,
    input logic                   rst,
    beacon_period_detect_if.slave bus
);
    localparam int unsigned   MW       = $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_CNT);

    bpd_state_t       state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] n_meas_q;
    logic [MW-1:0]    match_cnt;
    logic [MW-1:0]    mc_inc;
    logic             meas_valid_q;
    logic             locked_q;
    logic             rise;
    logic             match;

    beacon_sync_edge u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .en     (bus.en),
        .sig_in (bus.sig_in),
        .s      (),
        .rise   (rise)
    );

    always_comb begin
        diff   = (cnt >= bus.N_expect) ? cnt - bus.N_expect : bus.N_expect - cnt;
        match  = (diff <= bus.tol);
        mc_inc = (match_cnt == LOCK_MAX) ? match_cnt : match_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            n_meas_q     <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            if (bus.en) begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= MEASURE;
                            cnt   <= '0;
                        end
                    end
                    MEASURE: begin
                        // an edge on the all-ones count is a valid measurement, not a timeout
                        if (rise) begin
                            n_meas_q     <= cnt;
                            meas_valid_q <= 1'b1;
                            cnt          <= '0;
                            if (match) begin
                                match_cnt <= mc_inc;
                                if (mc_inc == LOCK_MAX) locked_q <= 1'b1;
                            end else begin
                                match_cnt <= '0;
                                locked_q  <= 1'b0;
                            end
                        end else if (cnt == '1) begin
                            state     <= IDLE;
                            match_cnt <= '0;
                            locked_q  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.n_meas     = n_meas_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.locked     = locked_q;
endmodule

// File: tb/tb_beacon_period_detect.sv
// Scoreboard bench for beacon_period_detect: WIDTH=16 instance for lock/tolerance/gating/reset,
// WIDTH=4 instance for counter timeout. Expected meas_valid cycle shifts by 2 clk under BEACON_SYNC_EN.
module tb_beacon_period_detect;
`ifdef BEACON_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct {
        int     n;
        int     lk;
        longint cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;

    beacon_period_detect_if #(.WIDTH(16)) b16 ();
    beacon_period_detect_if #(.WIDTH(4))  b4 ();

    beacon_period_detect #(.WIDTH(16), .LOCK_CNT(4)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    beacon_period_detect #(.WIDTH(4),  .LOCK_CNT(4)) dut4  (.clk(clk), .rst(rst), .bus(b4));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q16[$];
    exp_t q4[$];

    // per-instance reference state: index 0 = WIDTH 16, index 1 = WIDTH 4
    int     sel    = 0;
    int     en_div = 1;
    longint last_cyc;
    int     armed[2]   = '{0, 0};
    int     pending[2] = '{0, 0};
    int     mc[2]      = '{0, 0};
    int     lk[2]      = '{0, 0};
    int     nexp[2]    = '{0, 0};
    int     tolv[2]    = '{0, 0};
    int     maxv[2]    = '{65535, 15};
    logic   prev_mv16  = 1'b0;
    logic   prev_mv4   = 1'b0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic mon(input int id, input logic mv, input int n, input logic l, input logic pmv);
        exp_t e;
        if (mv) begin
            chk(id == 0 ? "mv_width16" : "mv_width4", longint'(pmv), 0);
            if ((id == 0 ? q16.size() : q4.size()) == 0) begin
                chk(id == 0 ? "spurious_mv16" : "spurious_mv4", longint'(mv), 0);
            end else begin
                e = (id == 0) ? q16.pop_front() : q4.pop_front();
                chk(id == 0 ? "n_meas16" : "n_meas4", n, e.n);
                chk(id == 0 ? "locked16" : "locked4", longint'(l), e.lk);
                chk(id == 0 ? "mv_cycle16" : "mv_cycle4", cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, b16.meas_valid, int'(b16.n_meas), b16.locked, prev_mv16);
        mon(1, b4.meas_valid, int'(b4.n_meas), b4.locked, prev_mv4);
        prev_mv16 <= b16.meas_valid;
        prev_mv4  <= b4.meas_valid;
    end

    task automatic set_bus(input logic e, input logic v);
        if (sel == 1) begin
            b4.en = e;  b4.sig_in = v;
        end else begin
            b16.en = e; b16.sig_in = v;
        end
    endtask

    task automatic set_param(input int ne, input int t);
        nexp[sel] = ne;
        tolv[sel] = t;
        if (sel == 1) begin
            b4.N_expect = 4'(ne);   b4.tol = 4'(t);
        end else begin
            b16.N_expect = 16'(ne); b16.tol = 16'(t);
        end
    endtask

    // one en sample of level v, preceded by en_div-1 idle clocks holding the same level
    task automatic drive_sample(input logic v);
        for (int i = 1; i < en_div; i++) begin
            @(posedge clk); #1;
            set_bus(1'b0, v);
        end
        @(posedge clk); #1;
        set_bus(1'b1, v);
        last_cyc = cyc;
    endtask

    task automatic rise_sample();
        exp_t e;
        int   d;
        int   emit;
        emit = armed[sel];
        if (emit != 0) begin
            d = (pending[sel] >= nexp[sel]) ? pending[sel] - nexp[sel] : nexp[sel] - pending[sel];
            if (d <= tolv[sel]) begin
                if (mc[sel] < 4) mc[sel]++;
                if (mc[sel] == 4) lk[sel] = 1;
            end else begin
                mc[sel] = 0;
                lk[sel] = 0;
            end
            e.n  = pending[sel];
            e.lk = lk[sel];
        end
        drive_sample(1'b1);
        if (emit != 0) begin
            e.cyc = last_cyc + 1 + ((en_div == 1) ? SYNC_LAT : 0);
            if (sel == 1) q4.push_back(e);
            else          q16.push_back(e);
        end
    endtask

    // divider-style waveform: rising edge followed by n more samples (period n+1)
    task automatic period(input int n);
        int h;
        h = (n + 1) / 2;
        rise_sample();
        for (int i = 1; i < h; i++) drive_sample(1'b1);
        for (int i = h; i <= n; i++) drive_sample(1'b0);
        pending[sel] = n;
        armed[sel]   = 1;
        if (n > maxv[sel]) begin
            armed[sel] = 0;
            mc[sel]    = 0;
            lk[sel]    = 0;
        end
    endtask

    task automatic closing();
        rise_sample();
        drive_sample(1'b0);
        armed[sel] = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        b16.en = 1'b1; b16.sig_in = 1'b0;
        b4.en  = 1'b1; b4.sig_in  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        b16.en = 1'b0; b4.en = 1'b0;
        @(negedge clk);
        chk("rst_n_meas16", b16.n_meas, 0);
        chk("rst_mv16", longint'(b16.meas_valid), 0);
        chk("rst_locked16", longint'(b16.locked), 0);
        for (int i = 0; i < 2; i++) begin
            armed[i] = 0; mc[i] = 0; lk[i] = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at t=%0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        b16.en = 1'b0; b16.sig_in = 1'b0; b16.N_expect = '0; b16.tol = '0;
        b4.en  = 1'b0; b4.sig_in  = 1'b0; b4.N_expect  = '0; b4.tol  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init_n_meas16", b16.n_meas, 0);
        chk("init_mv16", longint'(b16.meas_valid), 0);
        chk("init_locked16", longint'(b16.locked), 0);
        chk("init_n_meas4", b4.n_meas, 0);
        chk("init_locked4", longint'(b4.locked), 0);

        // basic lock, then tolerance band around N_expect=9
        sel = 0; en_div = 1;
        set_param(9, 0);
        repeat (5) period(9);
        set_param(9, 1);
        period(10);
        period(9);
        period(11);
        repeat (4) period(9);

        // reset while locked and part-way through a count
        rise_sample();
        repeat (3) drive_sample(1'b1);
        @(negedge clk);
        chk("locked_before_rst", longint'(b16.locked), lk[0]);
        do_reset();

        // strobe every 3rd clk; first edge after reset yields nothing
        sel = 0; en_div = 3;
        set_param(5, 0);
        repeat (6) period(5);
        closing();
        set_bus(1'b0, 1'b0);

        // WIDTH=4 counter timeout and the all-ones edge case
        sel = 1; en_div = 1;
        set_param(5, 0);
        repeat (5) period(5);
        period(16);
        repeat (1 + SYNC_LAT) @(posedge clk);
        #1 set_bus(1'b0, 1'b0);
        @(negedge clk);
        chk("timeout_locked4", longint'(b4.locked), lk[1]);
        repeat (5) period(5);
        period(15);
        closing();
        set_bus(1'b0, 1'b0);

        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("q16_drained", q16.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
